alu_muldiv_seq: RTL and testbench

- Parametrised multi-cycle arithmetic unit for the EX stage, covering the RV32M multiply/divide ops that the single-cycle combinational ALU does not have.
- Runs beside the existing ALU; the EX stage dispatches M-extension ops here through a valid/ready handshake.
- Iterative: one shift-add or restoring-divide step per clock.
- Flushable, so a pipeline kill drops an in-flight op.

---
 rtl/alu_muldiv_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M multiply/divide unit for the EX stage.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   flush           kill any accepted or in-flight op
//   in_valid/ready  op request handshake (ready only in IDLE)
//   op, rs1, rs2    funct3 and operands
//   tag_in/tag_out  sideband tag returned with the result
//   out_valid/ready result handshake; result held until taken
//   result          op result
//   busy            unit is in CALC or DONE
module alu_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [TAG_W-1:0]    r_tag;
    logic [XLEN-1:0]     r_m;
    logic [XLEN-1:0]     r_result;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg;
    logic [CW-1:0]       r_cnt;

    logic                w_accept;
    logic                w_is_div;
    logic                w_s1;
    logic                w_s2;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_neg_in;
    logic                w_div0;
    logic                w_ovf;
    logic                w_mul0;
    logic                w_special;
    logic [XLEN-1:0]     w_spec_res;
    logic                w_short;
    logic [XLEN-1:0]     w_short_res;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_sh;
    logic [XLEN:0]       w_div_diff;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fin;
    logic                w_last;

    // ---------------- accept-side decode ----------------
    assign w_accept = in_valid & in_ready & ~flush;
    assign w_is_div = op[2];

    // MUL only needs the low half, which is sign-agnostic.
    assign w_s1 = w_is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    assign w_s2 = w_is_div ? ~op[0] : (op[1:0] == 2'b01);
    assign w_sa = w_s1 & rs1[XLEN-1];
    assign w_sb = w_s2 & rs2[XLEN-1];
    assign w_a_mag = w_sa ? -rs1 : rs1;
    assign w_b_mag = w_sb ? -rs2 : rs2;

    // Remainder follows the dividend; everything else the xor of signs.
    assign w_neg_in = (w_is_div & op[1]) ? w_sa : (w_sa ^ w_sb);

    assign w_div0 = w_is_div & (rs2 == '0);
    assign w_ovf  = w_is_div & ~op[0] & (rs1 == MIN_NEG) & (rs2 == ALL_ONES);
    assign w_mul0 = ~w_is_div & ((rs1 == '0) | (rs2 == '0));
    assign w_special = w_div0 | w_ovf | w_mul0;

    always_comb begin
        w_spec_res = '0;
        unique case (1'b1)
            w_div0:  w_spec_res = op[1] ? rs1 : ALL_ONES;
            w_ovf:   w_spec_res = op[1] ? '0 : rs1;
            default: w_spec_res = '0;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_mag;
    logic [2*XLEN-1:0] w_fast_prod;
    logic [XLEN-1:0]   w_fast_res;

    assign w_fast_mag  = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
    assign w_fast_prod = w_neg_in ? -w_fast_mag : w_fast_mag;
    assign w_fast_res  = (op[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0]
                                            : w_fast_prod[2*XLEN-1:XLEN];
    assign w_short     = w_special | ~w_is_div;
    assign w_short_res = w_special ? w_spec_res : w_fast_res;
`else
    assign w_short     = w_special;
    assign w_short_res = w_spec_res;
`endif

    // ---------------- iteration step ----------------
    // Multiply: acc = {partial hi, multiplier}, shift right each step.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                     + {1'b0, (r_acc[0] ? r_m : {XLEN{1'b0}})};

    // Divide: acc = {remainder, dividend}, shift left each step.
    assign w_div_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff = w_div_sh - {1'b0, r_m};

    always_comb begin
        w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        if (r_op[2]) begin
            if (w_div_diff[XLEN])
                w_acc_next = {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            else
                w_acc_next = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
    end

    assign w_prod = r_neg ? -w_acc_next : w_acc_next;
    assign w_quo  = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    assign w_rem  = r_neg ? -w_acc_next[2*XLEN-1:XLEN]
                          : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        w_fin = w_rem;
        case (r_op)
            3'b000:                 w_fin = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fin = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fin = w_quo;
            default:                w_fin = w_rem;
        endcase
    end

    assign w_last = (r_cnt == CW'(XLEN-1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_short ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE: if (flush | out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    assign result  = r_result;
    assign tag_out = r_tag;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_tag    <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= op;
            r_tag <= tag_in;
            r_cnt <= '0;
            r_neg <= w_neg_in;
            r_m   <= w_is_div ? w_b_mag : w_a_mag;
            r_acc <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            if (w_short) r_result <= w_short_res;
        end else if (r_state == S_CALC && !flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_result <= w_fin;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed bench for alu_muldiv_seq with a
// reference model computed from plain 64-bit arithmetic.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;
    exp_t q[$];

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    alu_muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        r  = '0;
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Every cycle a result is presented it must match the model queue.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result got=%h want=none", result);
            end else begin
                if (result !== q[0].res || tag_out !== q[0].tag) begin
                    n_bad++;
                    $display("FAIL result_tag got=%h/%h want=%h/%h",
                             result, tag_out, q[0].res, q[0].tag);
                end
                if (out_ready && !flush) void'(q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t,
                         input int hold, input bit has_lit,
                         input logic [31:0] lit);
        int          lat;
        int          want_lat;
        bit          special;
        logic [31:0] r0;
        logic [4:0]  t0;
        special = (o[2] && b == 0)
               || ((o == 3'd4 || o == 3'd6)
                   && a == 32'h80000000 && b == 32'hFFFFFFFF)
               || (!o[2] && (a == 0 || b == 0));
        want_lat = (special || (!o[2] && FAST)) ? 1 : 33;
        chk("in_ready_pre", {31'b0, in_ready}, 32'd1);
        q.push_back('{res: model(o, a, b), tag: t});
        op        = o;
        rs1       = a;
        rs2       = b;
        tag_in    = t;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        tag_in   = 5'($urandom);
        lat      = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, want_lat);
        chk("tag_ret", {27'b0, tag_out}, {27'b0, t});
        if (has_lit) chk("literal", result, lit);
        r0 = result;
        t0 = tag_out;
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_res", result, r0);
            chk("hold_tag", {27'b0, tag_out}, {27'b0, t0});
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_inready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("retire_valid", {31'b0, out_valid}, 32'd0);
        chk("retire_inready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        rs1       = '0;
        rs2       = '0;
        tag_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inready", {31'b0, in_ready}, 32'd1);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag", {27'b0, tag_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 0, 1, 32'hFFFFFFEB);
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 0, 1, 32'hFFFFFFFE);
        do_op(3'd1, 32'h80000000, 32'h80000000, 5'd3, 0, 1, 32'h40000000);
        do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 0, 1, 32'hFFFFFFFF);
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'h13, 0, 1, 32'hFFFFFFFD);
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'h13, 0, 1, 32'hFFFFFFFF);
        do_op(3'd5, 32'd100, 32'd7, 5'h13, 0, 1, 32'd14);
        do_op(3'd7, 32'd100, 32'd7, 5'h13, 0, 1, 32'd2);
        do_op(3'd4, 32'h00ABCDEF, 32'd0, 5'd5, 0, 1, 32'hFFFFFFFF);
        do_op(3'd7, 32'h00001234, 32'd0, 5'd6, 0, 1, 32'h00001234);
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd7, 0, 1, 32'h80000000);
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd8, 0, 1, 32'd0);
        do_op(3'd0, 32'd0, 32'd5, 5'd9, 0, 1, 32'd0);
        do_op(3'd1, 32'h12345678, 32'd0, 5'd10, 0, 1, 32'd0);

        // Backpressure: result held for ten cycles.
        do_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd11, 10, 0, 32'd0);
        do_op(3'd4, 32'd9, 32'd0, 5'd12, 10, 0, 32'd0);

        // Flush during step 10 of a divide.
        op       = 3'd4;
        rs1      = 32'd1000;
        rs2      = 32'd7;
        tag_in   = 5'd14;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_inready", {31'b0, in_ready}, 32'd1);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_novalid", {31'b0, out_valid}, 32'd0);
        do_op(3'd5, 32'd9, 32'd3, 5'd15, 0, 1, 32'd3);

        // Flush coincident with accept.
        op       = 3'd5;
        rs1      = 32'd50;
        rs2      = 32'd5;
        tag_in   = 5'd16;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flacc_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flacc_novalid", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of an iteration.
        op       = 3'd4;
        rs1      = 32'd5000;
        rs2      = 32'd3;
        tag_in   = 5'd17;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_inready", {31'b0, in_ready}, 32'd1);
        chk("arst_result", result, 32'd0);
        chk("arst_tag", {27'b0, tag_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(3'd5, 32'd1000, 32'd7, 5'd18, 0, 1, 32'd142);
        do_op(3'd6, 32'h80000001, 32'd3, 5'd19, 1, 0, 32'd0);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            do_op(3'($urandom_range(0, 7)), a, b, 5'(i),
                  $urandom_range(0, 2), 0, 32'd0);
        end

        chk("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
